md_video_capture: RTL and testbench
===================================

Name: md_video_capture

Overview:
Upstream neighbour of the HDMI framebuffer. Takes the raw Genesis VDP pixel stream (pixel strobe, blanking flags, RGB) in the megadrive clock domain. Produces per-pixel write strobes with x/y coordinates, plus a measured, stability-filtered active frame width/height, so the framebuffer can address BRAM and scale correctly.
Handles H32/H40 and V28/V30 mode changes without glitching the reported geometry.

Parameters:
WIDTH, 320, max stored frame width; x is $clog2(WIDTH) bits
HEIGHT, 240, max stored frame height; y is $clog2(HEIGHT) bits
COLOR_BITS, 4, bits per colour channel
STABLE_FRAMES, 2, consecutive identical frame measurements needed before width/height update
DEF_WIDTH, 320, width after reset
DEF_HEIGHT, 224, height after reset
TIMEOUT_BITS, 21, watchdog counter width in clk cycles (no vblank seen -> unlock)

Ports:
clk  in  1  megadrive clock
resetn  in  1  asynchronous active-low reset
ce_pix  in  1  pixel strobe, one clk cycle per pixel
hblank  in  1  horizontal blank, valid on ce_pix
vblank  in  1  vertical blank, valid on ce_pix
r_in, g_in, b_in  in  COLOR_BITS each  pixel colour, valid on ce_pix
pix_we  out  1  one-cycle pixel write strobe
r, g, b  out  COLOR_BITS each  registered colour, valid with pix_we
x  out  $clog2(WIDTH)  pixel column, valid with pix_we
y  out  $clog2(HEIGHT)  pixel row, valid with pix_we
width  out  11  measured active width
height  out  10  measured active height
locked  out  1  geometry stable
frame_start  out  1  one-cycle pulse on vblank falling edge

Behaviour:
- Reset (async, resetn=0): pix_we=0, frame_start=0, r/g/b=0, x=0, y=0, width=DEF_WIDTH, height=DEF_HEIGHT, locked=0; all internal counters 0; previous hblank/vblank flags treated as 1.
- All sampling happens only on clk cycles with ce_pix=1. hblank/vblank edges are detected against the values latched at the previous ce_pix.
- Pixel path, latency 1 clk:
  - Active pixel means ce_pix & ~hblank & ~vblank.
  - On an active pixel, the next cycle drives pix_we=1 with r/g/b and the current x/y. Then the column counter increments.
  - pix_we is suppressed when column >= WIDTH or row >= HEIGHT; counting continues.
  - pix_we is never high two consecutive cycles unless ce_pix is.
- Column counter (11 bit, saturating at 2047): cleared on hblank falling edge.
- Line end (hblank rising edge while ~vblank):
  - line length = column count.
  - frame_max_w = max(frame_max_w, line length).
  - Row counter (10 bit, saturating at 1023) increments.
- Row counter is cleared on vblank falling edge. frame_start pulses for 1 clk on the cycle after that edge.
- Frame end (vblank rising edge): candidate (cand_w = frame_max_w, cand_h = row count).
  - cand_h==0 or cand_w==0: frame ignored; match counter and locked unchanged.
  - cand equals previous candidate: match counter increments, saturating at STABLE_FRAMES. When it reaches STABLE_FRAMES-1 matches (i.e. STABLE_FRAMES identical frames), width/height are loaded and locked=1 on the next clk.
  - cand differs: match counter=0, locked=0; width/height hold their old values.
  - frame_max_w is cleared after the comparison.
- Simultaneous hblank rise and vblank rise on the same ce_pix: the line end is not counted; only the frame end is processed.
- Watchdog: counts clk, cleared on every vblank rising edge. On overflow: locked=0, match counter=0; width/height hold.
- Reset mid-frame: all counting restarts. The first frame after reset is never written to width/height until STABLE_FRAMES full frames are seen. Pixels before the first vblank falling edge use row 0 upward normally (no suppression beyond WIDTH/HEIGHT limits).

Decomposition:
- Package md_video_pkg: WIDTH/HEIGHT defaults, H32=256, H40=320, V28=224, V30=240 constants, and a typedef geom_t {logic [10:0] w; logic [9:0] h}.
- One sub-module, blank_edge_det: ce-qualified rise/fall detector for hblank and vblank. Instantiate it twice.
- Counters and the stability FSM stay in the top module.

Test Plan:
- H40/V28 stream, ce_pix every 4 clk, 320 active px/line, 224 lines: first 2 frames -> locked=0, width=320, height=224. After frame 2 vblank rise -> locked=1, width=320, height=224. The last pixel of a line gives pix_we with x=319.
- Switch to H32/V30 (256x240) mid-operation: first differing frame -> locked=0, width stays 320. After 2 frames of 256x240 -> width=256, height=240, locked=1.
- Stream with 330 px/line and 250 lines (WIDTH=320, HEIGHT=240): no pix_we with x>=320 or y>=240. Measured width=330, height=250.
- Stop vblank entirely after lock: after 2^21 clk -> locked=0, width/height unchanged.
- Assert resetn=0 mid-line for 3 clk: outputs go to reset values immediately without waiting for clk. Re-lock needs 2 full frames.
- hblank and vblank rise on the same ce_pix: the row count is not incremented, and the frame measured as 224 rows, not 225.

Source files
------------

// File: rtl/md_video_pkg.sv
// Shared constants and types for the Mega Drive VDP capture front end.
package md_video_pkg;

  localparam int unsigned H32 = 256;
  localparam int unsigned H40 = 320;
  localparam int unsigned V28 = 224;
  localparam int unsigned V30 = 240;

  localparam int unsigned DefFrameWidth  = H40;
  localparam int unsigned DefFrameHeight = V30;

  typedef struct packed {
    logic [10:0] w;
    logic [9:0]  h;
  } geom_t;

  typedef enum logic {
    StUnlocked,
    StLocked
  } lock_state_e;

endpackage

// File: rtl/md_video_capture_blank_edge_det.sv
// Pixel-strobe-qualified rise/fall detector for a blanking flag.
module blank_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic ce_pix,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev_q;

  // Previous level resets high so a stream entering mid-frame sees a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 1'b1;
    end else if (ce_pix) begin
      prev_q <= level;
    end
  end

  assign rise = ce_pix & level & ~prev_q;
  assign fall = ce_pix & ~level & prev_q;

endmodule

// File: rtl/md_video_capture.sv
// VDP pixel stream capture: pixel write strobes with x/y plus a stability-filtered frame geometry.
module md_video_capture
  import md_video_pkg::*;
#(
  parameter int unsigned WIDTH         = DefFrameWidth,
  parameter int unsigned HEIGHT        = DefFrameHeight,
  parameter int unsigned COLOR_BITS    = 4,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned DEF_WIDTH     = H40,
  parameter int unsigned DEF_HEIGHT    = V28,
  parameter int unsigned TIMEOUT_BITS  = 21
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ce_pix,
  input  logic                      hblank,
  input  logic                      vblank,
  input  logic [COLOR_BITS-1:0]     r_in,
  input  logic [COLOR_BITS-1:0]     g_in,
  input  logic [COLOR_BITS-1:0]     b_in,
  output logic                      pix_we,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic [10:0]               width,
  output logic [9:0]                height,
  output logic                      locked,
  output logic                      frame_start
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);

  localparam logic [10:0]   WidthLim  = 11'(WIDTH);
  localparam logic [9:0]    HeightLim = 10'(HEIGHT);
  localparam logic [MW-1:0] MatchMax  = MW'(STABLE_FRAMES);
  localparam logic [MW-1:0] MatchLock = MW'(STABLE_FRAMES - 1);
  localparam geom_t         DefGeom   = '{w: 11'(DEF_WIDTH), h: 10'(DEF_HEIGHT)};

  logic hb_rise, hb_fall, vb_rise, vb_fall, active;

  blank_edge_det u_hblank_det (
    .clk    (clk),
    .resetn (resetn),
    .ce_pix (ce_pix),
    .level  (hblank),
    .rise   (hb_rise),
    .fall   (hb_fall)
  );

  blank_edge_det u_vblank_det (
    .clk    (clk),
    .resetn (resetn),
    .ce_pix (ce_pix),
    .level  (vblank),
    .rise   (vb_rise),
    .fall   (vb_fall)
  );

  assign active = ce_pix & ~hblank & ~vblank;

  logic [10:0]             col_q, col_d, col_base, max_w_q, max_w_d;
  logic [9:0]              row_q, row_d, row_base;
  logic                    pix_we_q, pix_we_d, frame_start_q;
  logic [COLOR_BITS-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  geom_t                   cand, prev_q, prev_d, geom_q, geom_d;
  logic [MW-1:0]           match_q, match_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  lock_state_e             state_q, state_d;

  always_comb begin
    col_base = hb_fall ? '0 : col_q;
    row_base = vb_fall ? '0 : row_q;
    col_d    = col_base;
    row_d    = row_base;
    max_w_d  = max_w_q;
    pix_we_d = 1'b0;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    cand.w   = max_w_q;
    cand.h   = row_q;
    prev_d   = prev_q;
    geom_d   = geom_q;
    match_d  = match_q;
    state_d  = state_q;
    wd_d     = wd_q + 1'b1;

    if (active) begin
      pix_we_d = (col_base < WidthLim) && (row_base < HeightLim);
      r_d      = r_in;
      g_d      = g_in;
      b_d      = b_in;
      x_d      = col_base[XW-1:0];
      y_d      = row_base[YW-1:0];
      col_d    = (col_base == '1) ? col_base : col_base + 1'b1;
    end

    // A line that ends on the same strobe as vblank rises is not counted.
    if (hb_rise && !vblank) begin
      if (col_q > max_w_q) max_w_d = col_q;
      row_d = (row_base == '1) ? row_base : row_base + 1'b1;
    end

    if (vb_rise) begin
      wd_d    = '0;
      max_w_d = '0;
      if (cand.w != '0 && cand.h != '0) begin
        if (cand == prev_q) begin
          if (match_q < MatchMax) match_d = match_q + 1'b1;
          if (match_d >= MatchLock) begin
            geom_d  = cand;
            state_d = StLocked;
          end
        end else begin
          prev_d  = cand;
          match_d = '0;
          state_d = StUnlocked;
        end
      end
    end else if (wd_q == '1) begin
      match_d = '0;
      state_d = StUnlocked;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q         <= '0;
      row_q         <= '0;
      max_w_q       <= '0;
      pix_we_q      <= 1'b0;
      frame_start_q <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      prev_q        <= '0;
      geom_q        <= DefGeom;
      match_q       <= '0;
      wd_q          <= '0;
      state_q       <= StUnlocked;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      max_w_q       <= max_w_d;
      pix_we_q      <= pix_we_d;
      frame_start_q <= vb_fall;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      x_q           <= x_d;
      y_q           <= y_d;
      prev_q        <= prev_d;
      geom_q        <= geom_d;
      match_q       <= match_d;
      wd_q          <= wd_d;
      state_q       <= state_d;
    end
  end

  assign pix_we      = pix_we_q;
  assign frame_start = frame_start_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign x           = x_q;
  assign y           = y_q;
  assign width       = geom_q.w;
  assign height      = geom_q.h;
  assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_md_video_capture.sv
// Bench for md_video_capture: scaled-down frames, pixel scoreboard and geometry reference model.
module tb_md_video_capture;

  localparam int W        = 40;
  localparam int H        = 30;
  localparam int CB       = 4;
  localparam int SF       = 2;
  localparam int TB       = 14;
  localparam int VB_LINES = 2;
  localparam int HB_PX    = 4;
  localparam int VB_PX    = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ce_pix = 1'b0;
  logic          hblank = 1'b1;
  logic          vblank = 1'b1;
  logic [CB-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          pix_we, locked, frame_start;
  logic [CB-1:0] r, g, b;
  logic [5:0]    x;
  logic [4:0]    y;
  logic [10:0]   width;
  logic [9:0]    height;

  md_video_capture #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .COLOR_BITS    (CB),
    .STABLE_FRAMES (SF),
    .DEF_WIDTH     (320),
    .DEF_HEIGHT    (224),
    .TIMEOUT_BITS  (TB)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ce_pix      (ce_pix),
    .hblank      (hblank),
    .vblank      (vblank),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .pix_we      (pix_we),
    .r           (r),
    .g           (g),
    .b           (b),
    .x           (x),
    .y           (y),
    .width       (width),
    .height      (height),
    .locked      (locked),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int r;
    int g;
    int b;
  } pix_t;

  typedef struct {
    int w;
    int h;
    bit co;
    int ew;
    int eh;
    bit el;
  } vec_t;

  pix_t exp_q[$];
  vec_t tbl[9];
  int   n_tests = 0;
  int   n_fail = 0;
  int   fs_seen = 0;
  int   fs_exp = 0;

  // Reference geometry model: run = consecutive identical valid frames.
  int m_w = 320, m_h = 224, m_lock = 0, m_pw = 0, m_ph = 0, m_run = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_geom(input string name, input int ew, input int eh, input int el);
    check({name, "_width"}, int'(width), ew);
    check({name, "_height"}, int'(height), eh);
    check({name, "_locked"}, int'(locked), el);
  endtask

  task automatic model_frame_end(input int mw, input int mh);
    if (mw != 0 && mh != 0) begin
      if (mw == m_pw && mh == m_ph) begin
        m_run++;
      end else begin
        m_run  = 1;
        m_pw   = mw;
        m_ph   = mh;
        m_lock = 0;
      end
      if (m_run >= SF) begin
        m_lock = 1;
        m_w    = mw;
        m_h    = mh;
      end
    end
  endtask

  task automatic model_reset();
    m_w = 320; m_h = 224; m_lock = 0; m_pw = 0; m_ph = 0; m_run = 0;
  endtask

  task automatic monitor_loop();
    pix_t e;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1) fs_seen++;
      if (pix_we === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pix_unexpected: got write x=%0d y=%0d, expected none", x, y);
        end else begin
          e = exp_q.pop_front();
          if (int'(x) != e.x || int'(y) != e.y || int'(r) != e.r || int'(g) != e.g ||
              int'(b) != e.b) begin
            n_fail++;
            $display("FAIL pix_data: got x=%0d y=%0d rgb=%0d,%0d,%0d, expected x=%0d y=%0d rgb=%0d,%0d,%0d",
                     x, y, r, g, b, e.x, e.y, e.r, e.g, e.b);
          end
        end
      end
    end
  endtask

  // One pixel strobe followed by 1..3 idle clocks.
  task automatic send_pix(input bit hb, input bit vb, input int col, input int row);
    pix_t e;
    @(negedge clk);
    ce_pix = 1'b1;
    hblank = hb;
    vblank = vb;
    r_in   = CB'($urandom);
    g_in   = CB'($urandom);
    b_in   = CB'($urandom);
    if (!hb && !vb && col < W && row < H) begin
      e = '{x: col, y: row, r: int'(r_in), g: int'(g_in), b: int'(b_in)};
      exp_q.push_back(e);
    end
    @(negedge clk);
    ce_pix = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input int h, input bit co, input bit randw);
    int mw = 0, mh = 0, len;
    bit last;
    for (int l = 0; l < h; l++) begin
      len  = randw ? int'($urandom_range(1, w)) : w;
      last = (l == h - 1);
      for (int c = 0; c < len; c++) send_pix(1'b0, 1'b0, c, l);
      for (int c = 0; c < HB_PX; c++) send_pix(1'b1, co && last, 0, 0);
      if (!(co && last)) begin
        mh++;
        if (len > mw) mw = len;
      end
    end
    if (h > 0) fs_exp++;
    for (int l = 0; l < VB_LINES; l++) begin
      for (int c = 0; c < VB_PX; c++) send_pix(1'b0, 1'b1, 0, 0);
      for (int c = 0; c < HB_PX; c++) send_pix(1'b1, 1'b1, 0, 0);
    end
    model_frame_end(mw, mh);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{32, 24, 0, 320, 224, 0};
    tbl[1] = '{32, 24, 0, 32, 24, 1};
    tbl[2] = '{24, 30, 0, 32, 24, 0};
    tbl[3] = '{24, 30, 0, 24, 30, 1};
    tbl[4] = '{24, 30, 0, 24, 30, 1};
    tbl[5] = '{46, 34, 0, 24, 30, 0};
    tbl[6] = '{46, 34, 0, 46, 34, 1};
    tbl[7] = '{32, 25, 1, 46, 34, 0};
    tbl[8] = '{32, 25, 1, 32, 24, 1};

    fork
      monitor_loop();
    join_none

    repeat (2) @(negedge clk);
    #1;
    check_geom("reset", 320, 224, 0);
    check("reset_pix_we", int'(pix_we), 0);
    check("reset_frame_start", int'(frame_start), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].w, tbl[i].h, tbl[i].co, 1'b0);
      check_geom($sformatf("tbl%0d", i), tbl[i].ew, tbl[i].eh, int'(tbl[i].el));
    end

    // Zero-height frame: vblank drops only during hblank and rises again.
    for (int c = 0; c < 3; c++) send_pix(1'b1, 1'b0, 0, 0);
    for (int c = 0; c < 2; c++) send_pix(1'b1, 1'b1, 0, 0);
    fs_exp++;
    model_frame_end(0, 0);
    check_geom("empty_frame", m_w, m_h, m_lock);

    for (int k = 0; k < 3; k++) begin
      send_frame(int'($urandom_range(1, 46)), int'($urandom_range(1, 34)), 1'b0, 1'b1);
      check_geom($sformatf("rand%0d", k), m_w, m_h, m_lock);
    end
    for (int k = 0; k < 2; k++) begin
      send_frame(24, 30, 1'b0, 1'b0);
      check_geom($sformatf("relock%0d", k), m_w, m_h, m_lock);
    end

    // Watchdog: no vblank activity at all.
    check("wd_pre_locked", int'(locked), 1);
    repeat ((1 << TB) + 64) @(negedge clk);
    m_lock = 0;
    if (m_run > 0) m_run = 1;
    check_geom("watchdog", m_w, m_h, m_lock);
    send_frame(24, 30, 1'b0, 1'b0);
    check_geom("wd_relock", m_w, m_h, m_lock);

    // Reset in the middle of a line.
    for (int c = 0; c < 10; c++) send_pix(1'b0, 1'b0, c, 0);
    fs_exp++;
    check("pre_reset_queue", exp_q.size(), 0);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check_geom("midreset", 320, 224, 0);
    check("midreset_pix_we", int'(pix_we), 0);
    check("midreset_x", int'(x), 0);
    check("midreset_y", int'(y), 0);
    check("midreset_rgb", int'({r, g, b}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    send_frame(32, 10, 1'b0, 1'b0);
    check_geom("post_reset0", m_w, m_h, m_lock);
    send_frame(32, 24, 1'b0, 1'b0);
    check_geom("post_reset1", m_w, m_h, m_lock);
    send_frame(32, 24, 1'b0, 1'b0);
    check_geom("post_reset2", m_w, m_h, m_lock);

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("frame_start_count", fs_seen, fs_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
